hash_tx_streamer: RTL
=====================

// Module: hash_tx_streamer
// PURPOSE
//  Consumes the 512-bit SHA3-512 digest (hash/out_valid from the SHA driver) and streams it
//  to the UART transmitter one byte per valid/ready handshake, MSB first. It is the read-back
//  end of the hashing path: UART RX -> word packer -> SHA -> this block -> UART TX.
//  It has two output modes: raw bytes, or lowercase ASCII hex with an optional CR/LF trailer.
// PARAMETERS
//  HASH_W      512  digest width in bits; must be a multiple of 8.
//  HEX_MODE    1    1: emit 2 ASCII hex chars per byte (HASH_W/4 chars); 0: emit HASH_W/8 raw bytes.
//  APPEND_CRLF 1    1: append 8'h0D then 8'h0A after the digest. Applies in HEX_MODE only.
// PORTS
//  clk_i         in   1       system clock.
//  rst_i         in   1       synchronous, active-high reset.
//  hash_i        in   HASH_W  digest from the SHA driver; sampled only on capture.
//  hash_valid_i  in   1       level-high "digest valid" from the SHA driver.
//  tx_data_o     out  8       byte or character to the UART TX.
//  tx_valid_o    out  1       tx_data_o is valid.
//  tx_ready_i    in   1       UART TX accepts tx_data_o this cycle.
//  busy_o        out  1       high from capture until the last byte is accepted.
//  done_o        out  1       1-cycle pulse in the cycle after the final handshake.
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge):
//   - state=IDLE; tx_valid_o=0; tx_data_o=0; busy_o=0; done_o=0; index=0; shift reg=0.
//   - valid_q (registered hash_valid_i) resets to 1. A hash_valid_i held high through reset
//     is therefore not re-sent; a low cycle is required before the next capture.
//   - Reset during streaming aborts at once. The remaining bytes are dropped and no done pulse
//     is produced.
//  Capture:
//   - Occurs in IDLE when hash_valid_i=1 and valid_q=0 (rising edge).
//   - hash_i is loaded into the shift register; busy_o=1.
//   - tx_valid_o=1 with the first byte/char in the cycle after the capture edge (latency 1).
//   - Edges seen while not IDLE are ignored, with no queueing. A level held high never retriggers.
//  Handshake:
//   - Transfer occurs on a cycle with tx_valid_o && tx_ready_i.
//   - tx_data_o and tx_valid_o hold stable until the transfer; tx_valid_o never drops
//     without a transfer.
//   - Next item is presented in the following cycle. Throughput is 1 item/cycle under
//     continuous ready.
//  Data ordering:
//   - Raw mode: byte k = hash[HASH_W-1-8k -: 8], k = 0..HASH_W/8-1.
//   - Hex mode: char j is nibble hash[HASH_W-1-4j -: 4].
//   - Hex encoding: nibble 0-9 -> 8'h30-8'h39; nibble a-f -> 8'h61-8'h66.
//   - The shift register shifts left by 4 (hex) or 8 (raw) per transfer.
//   - The index counter is $clog2(HASH_W/4)+1 bits wide and saturates at the last item;
//     it never wraps.
//  States:
//   - IDLE -> SEND on capture.
//   - SEND -> CR when the last digest item transfers and APPEND_CRLF&&HEX_MODE; otherwise
//     SEND -> DONE.
//   - CR (8'h0D) -> LF (8'h0A) -> DONE, each on transfer.
//   - DONE: done_o=1 and busy_o=0 for one cycle, then -> IDLE.
//  Simultaneous events:
//   - rst_i wins over everything.
//   - A capture edge coinciding with DONE is ignored. valid_q still updates, so that edge is lost.
// STRUCTURE
//  Package sha_stream_pkg:
//   - typedef enum {TX_IDLE, TX_SEND, TX_CR, TX_LF, TX_DONE} tx_state_e;
//   - localparams ASCII_CR=8'h0D and ASCII_LF=8'h0A;
//   - function nib2hex(logic [3:0]) -> logic [7:0].
//  One sub-module is natural: hash_tx_fsm (state, index counter, handshake).
//  The datapath (shift register, hex mux) stays in the top level.
// TESTING
//  1. HEX_MODE=1, CRLF=1; hash_i = {16{32'h0123_89AB}}; one hash_valid_i pulse; tx_ready_i=1
//     -> 130 transfers: "012389ab" x16, then 0x0D, 0x0A. tx_valid_o first high 1 cycle after
//     the edge. done_o pulses once, 131 cycles after the edge.
//  2. Same digest; tx_ready_i random at 30% duty -> identical byte sequence; tx_data_o never
//     changes while tx_valid_o && !tx_ready_i.
//  3. hash_valid_i held high 500 cycles -> exactly one stream. Drop it for 1 cycle and raise
//     it again -> a second identical stream.
//  4. Assert rst_i after 40 transfers -> tx_valid_o=0 in the next cycle, no done_o. With
//     hash_valid_i high across reset, no new stream starts until a low->high edge.
//  5. HEX_MODE=0; hash_i = 512'hFF00...00A5 -> 64 raw bytes: 0xFF, 0x00 x62, 0xA5; no CR/LF;
//     done_o after the 64th transfer.
//  6. A second hash_valid_i edge mid-stream -> ignored. The stream completes with the first
//     captured digest, unchanged by any hash_i changes.

Source files
------------

// File: rtl/hash_tx_streamer_pkg.sv
// Shared types and helpers for the digest read-back path.
// Holds the TX FSM state encoding, ASCII constants and the nibble-to-hex encoder.
package sha_stream_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND,
    TX_CR,
    TX_LF,
    TX_DONE
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex: 0-9 -> '0'-'9', a-f -> 'a'-'f'.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    logic [7:0] n;
    n = {4'h0, nib};
    if (nib < 4'd10) return 8'h30 + n;
    else             return 8'h57 + n;
  endfunction

endpackage

// File: rtl/hash_tx_streamer_if.sv
// Byte stream valid/ready bus toward the UART transmitter.
// master: drives tx_data/tx_valid, samples tx_ready. slave: the opposite.
interface hash_tx_streamer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/hash_tx_streamer_fsm.sv
// Sequencer for the digest streamer: state, item index and handshake.
// Ports: clk_i, rst_i, capture_i, tx_ready_i -> state_o, tx_valid_o, xfer_o, busy_o, done_o.
module hash_tx_fsm
  import sha_stream_pkg::*;
#(
  parameter int N_ITEMS = 128,
  parameter int IDX_W   = 8,
  parameter bit CRLF    = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      capture_i,
  input  logic      tx_ready_i,
  output tx_state_e state_o,
  output logic      tx_valid_o,
  output logic      xfer_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITEMS - 1);

  tx_state_e        state_q;
  logic [IDX_W-1:0] idx_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             xfer;

  assign xfer = tx_valid_q && tx_ready_i;

  // The index stops at LAST: the last item moves the FSM on
  // instead of advancing the counter, so it cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= TX_IDLE;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          if (capture_i) begin
            state_q    <= TX_SEND;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        TX_SEND: begin
          if (xfer) begin
            if (idx_q == LAST) begin
              if (CRLF) begin
                state_q <= TX_CR;
              end else begin
                state_q    <= TX_DONE;
                tx_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        TX_CR: begin
          if (xfer) state_q <= TX_LF;
        end
        TX_LF: begin
          if (xfer) begin
            state_q    <= TX_DONE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        TX_DONE: begin
          state_q <= TX_IDLE;
          idx_q   <= '0;
        end
        default: begin
          state_q    <= TX_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign state_o    = state_q;
  assign tx_valid_o = tx_valid_q;
  assign xfer_o     = xfer;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: rtl/hash_tx_streamer.sv
// Streams a captured digest to the UART TX, MSB first, as raw bytes or lowercase hex.
// Ports: clk_i, rst_i, hash_i, hash_valid_i, tx_if (master), busy_o, done_o.
module hash_tx_streamer
  import sha_stream_pkg::*;
#(
  parameter int HASH_W      = 512,
  parameter int HEX_MODE    = 1,
  parameter int APPEND_CRLF = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HASH_W-1:0]    hash_i,
  input  logic                 hash_valid_i,
  hash_tx_streamer_if.master   tx_if,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam bit HEX     = (HEX_MODE != 0);
  localparam bit CRLF    = HEX && (APPEND_CRLF != 0);
  localparam int N_ITEMS = HEX ? HASH_W / 4 : HASH_W / 8;
  localparam int IDX_W   = $clog2(HASH_W / 4) + 1;
  localparam int SH      = HEX ? 4 : 8;

  tx_state_e         state;
  logic              xfer;
  logic              capture;
  logic              valid_q;
  logic [HASH_W-1:0] sh_q;
  logic [HASH_W-1:0] sh_d;
  logic [7:0]        data;

  // Resets high so a level held through reset is not taken as a new edge.
  assign capture = (state == TX_IDLE) && hash_valid_i && !valid_q;

  hash_tx_fsm #(
    .N_ITEMS (N_ITEMS),
    .IDX_W   (IDX_W),
    .CRLF    (CRLF)
  ) u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .capture_i  (capture),
    .tx_ready_i (tx_if.tx_ready),
    .state_o    (state),
    .tx_valid_o (tx_if.tx_valid),
    .xfer_o     (xfer),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always_comb begin
    sh_d = sh_q;
    if (capture) begin
      sh_d = hash_i;
    end else if (xfer && state == TX_SEND) begin
      sh_d = sh_q << SH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b1;
      sh_q    <= '0;
    end else begin
      valid_q <= hash_valid_i;
      sh_q    <= sh_d;
    end
  end

  // Output is decoded from registered state only, so it is
  // stable for as long as the handshake is stalled.
  always_comb begin
    data = 8'h00;
    unique case (state)
      TX_SEND: begin
        if (HEX) data = nib2hex(sh_q[HASH_W-1 -: 4]);
        else     data = sh_q[HASH_W-1 -: 8];
      end
      TX_CR:   data = ASCII_CR;
      TX_LF:   data = ASCII_LF;
      default: data = 8'h00;
    endcase
  end

  assign tx_if.tx_data = data;

endmodule
